// File: rtl/button_conditioner.sv
// Debounced, play-mode-gated pushbutton conditioner for left/right/shoot controls.
// Optional shoot auto-repeat is compiled in when BUTTON_AUTOFIRE_EN is defined.

module button_debounce #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o,
`ifdef BUTTON_AUTOFIRE_EN
   output logic held_o,
`endif
   output logic press_o
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  sync_q;
   logic        sync;
   logic [19:0] cnt_q, cnt_d;
   logic [19:0] cnt_inc;
   logic        cnt_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], raw_i};
      end
   end

   assign sync = sync_q[1];

   // The count includes the cycle in which the new level was first seen.
   assign cnt_inc  = (cnt_q >= DEBOUNCE_CYCLES) ? cnt_q : cnt_q + 20'd1;
   assign cnt_done = (cnt_inc >= DEBOUNCE_CYCLES);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (sync) begin
               state_d = PRESS_WAIT;
               cnt_d   = 20'd1;
            end
         end
         PRESS_WAIT: begin
            if (!sync) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_done) begin
               state_d = HELD;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
         HELD: begin
            if (!sync) begin
               state_d = RELEASE_WAIT;
               cnt_d   = 20'd1;
            end
         end
         RELEASE_WAIT: begin
            if (sync) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_done) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      level_o = (state_q == HELD) || (state_q == RELEASE_WAIT);
      press_o = (state_q == PRESS_WAIT) && (state_d == HELD);
`ifdef BUTTON_AUTOFIRE_EN
      held_o  = (state_q == HELD);
`endif
   end

endmodule

module button_conditioner #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
   parameter logic [25:0] AUTOFIRE_CYCLES = 26'd25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_left_raw,
   input  logic        btn_right_raw,
   input  logic        btn_shoot_raw,
   input  logic [1:0]  mode,
   input  logic [10:0] xCoord,
   input  logic [9:0]  yCoord,
   output logic        button_left,
   output logic        button_right,
   output logic        button_shoot
);

   logic left_lvl, right_lvl, shoot_lvl;
   logic left_press, right_press, shoot_press;
   logic play, frame_start, fire;
   logic left_q, left_d, right_q, right_d;
   logic pending_q, pending_d;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (btn_left_raw),
      .level_o (left_lvl),
`ifdef BUTTON_AUTOFIRE_EN
      .held_o  (),
`endif
      .press_o (left_press)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (btn_right_raw),
      .level_o (right_lvl),
`ifdef BUTTON_AUTOFIRE_EN
      .held_o  (),
`endif
      .press_o (right_press)
   );

`ifdef BUTTON_AUTOFIRE_EN
   logic        shoot_held;
   logic        af_fire;
   logic [25:0] af_cnt_q, af_cnt_d;
`endif

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_shoot (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (btn_shoot_raw),
      .level_o (shoot_lvl),
`ifdef BUTTON_AUTOFIRE_EN
      .held_o  (shoot_held),
`endif
      .press_o (shoot_press)
   );

   assign play        = (mode == 2'd2);
   assign frame_start = (xCoord == '0) && (yCoord == '0);

`ifdef BUTTON_AUTOFIRE_EN
   // Counter restarts at each repeat so requests are AUTOFIRE_CYCLES apart.
   always_comb begin
      af_cnt_d = '0;
      af_fire  = 1'b0;
      if (shoot_held && play) begin
         if (af_cnt_q >= AUTOFIRE_CYCLES - 26'd1) begin
            af_fire  = 1'b1;
         end else begin
            af_cnt_d = af_cnt_q + 26'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         af_cnt_q <= '0;
      end else begin
         af_cnt_q <= af_cnt_d;
      end
   end

   assign fire = shoot_press | af_fire;
`else
   assign fire = shoot_press;
`endif

   // A request arriving on the consuming frame_start is dropped only if one is already pending.
   always_comb begin
      pending_d = pending_q;
      if (!play) begin
         pending_d = 1'b0;
      end else if (frame_start && pending_q) begin
         pending_d = 1'b0;
      end else if (fire) begin
         pending_d = 1'b1;
      end
   end

   always_comb begin
      left_d  = left_lvl  & play & ~right_lvl;
      right_d = right_lvl & play & ~left_lvl;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         left_q    <= 1'b0;
         right_q   <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         left_q    <= left_d;
         right_q   <= right_d;
         pending_q <= pending_d;
      end
   end

   assign button_left  = left_q;
   assign button_right = right_q;
   assign button_shoot = pending_q;

   logic unused_ok;
   assign unused_ok = &{1'b0, left_press, right_press, shoot_lvl};

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: drivers queue hand-timed output transitions, a negedge monitor matches them.
// Expected autofire behaviour follows BUTTON_AUTOFIRE_EN.

module tb_button_conditioner;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        bl = 1'b0, br = 1'b0, bs = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [10:0] x = 11'd5;
   logic [9:0]  y = 10'd5;
   logic        o_left, o_right, o_shoot;

   always #5 clk = ~clk;

   button_conditioner #(
      .DEBOUNCE_CYCLES(20'd4),
      .AUTOFIRE_CYCLES(26'd40)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_left_raw  (bl),
      .btn_right_raw (br),
      .btn_shoot_raw (bs),
      .mode          (mode),
      .xCoord        (x),
      .yCoord        (y),
      .button_left   (o_left),
      .button_right  (o_right),
      .button_shoot  (o_shoot)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int shoot_rises = 0;

   typedef struct {
      int   sig;
      logic val;
      int   at;
   } ev_t;

   ev_t        exp_q[$];
   bit         mon_en = 1'b0;
   logic [2:0] prev;
   logic [2:0] mon_cur;
   ev_t        mon_e;
   string      names[3] = '{"button_left", "button_right", "button_shoot"};

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int s, input logic v, input int at);
      ev_t e;
      e.sig = s;
      e.val = v;
      e.at  = at;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic drain(input string nm);
      chk({nm, " missing events"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic frame(input bit on);
      if (on) begin
         x = 11'd0;
         y = 10'd0;
      end else begin
         x = 11'd100;
         y = 10'd50;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_cur = {o_shoot, o_right, o_left};
         for (int s = 0; s < 3; s++) begin
            if (mon_cur[s] !== prev[s]) begin
               checks++;
               if (s == 2 && mon_cur[2] === 1'b1) shoot_rises++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected %s actual=%0b at cycle %0d required no change",
                           names[s], mon_cur[s], cyc);
               end else begin
                  mon_e = exp_q.pop_front();
                  if (mon_e.sig != s || mon_e.val !== mon_cur[s] || mon_e.at != cyc) begin
                     errors++;
                     $display("FAIL event actual %s=%0b at cycle %0d required %s=%0b at cycle %0d",
                              names[s], mon_cur[s], cyc, names[mon_e.sig], mon_e.val, mon_e.at);
                  end
               end
            end
         end
         prev = mon_cur;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int t, f, q, b, c, base;

      // Reset with left already held and play mode selected
      mode = 2'd2;
      bl   = 1'b1;
      tick(3);
      @(negedge clk);
      chk("reset left",  o_left,  0);
      chk("reset right", o_right, 0);
      chk("reset shoot", o_shoot, 0);
      @(posedge clk);
      #1;
      q   = cyc;
      rst = 1'b1;
      push(0, 1'b1, q + 7);
      tick(1);
      @(negedge clk);
      chk("post-release left",  o_left,  0);
      chk("post-release right", o_right, 0);
      chk("post-release shoot", o_shoot, 0);
      prev   = {o_shoot, o_right, o_left};
      mon_en = 1'b1;
      tick(8);
      t  = cyc;
      bl = 1'b0;
      push(0, 1'b0, t + 7);
      tick(10);
      drain("held across reset");

      // Bouncing left, then a clean hold
      for (int i = 0; i < 5; i++) begin
         bl = 1'b1;
         tick(2);
         bl = 1'b0;
         tick(2);
      end
      t  = cyc;
      bl = 1'b1;
      push(0, 1'b1, t + 7);
      tick(12);
      t  = cyc;
      bl = 1'b0;
      push(0, 1'b0, t + 7);
      tick(10);
      drain("bounce");

      // Single shoot press consumed at a later frame_start
      t  = cyc;
      bs = 1'b1;
      push(2, 1'b1, t + 6);
      tick(10);
      bs = 1'b0;
      tick(30);
      f = cyc;
      frame(1'b1);
      push(2, 1'b0, f + 1);
      tick(1);
      frame(1'b0);
      tick(5);
      drain("shoot consume");

      // Two presses share one request
      t  = cyc;
      bs = 1'b1;
      push(2, 1'b1, t + 6);
      tick(8);
      bs = 1'b0;
      tick(10);
      bs = 1'b1;
      tick(8);
      bs = 1'b0;
      tick(10);
      f = cyc;
      frame(1'b1);
      push(2, 1'b0, f + 1);
      tick(1);
      frame(1'b0);
      tick(5);
      drain("two presses");

      // Left+right together, release right, mode gating, right alone
      bl = 1'b1;
      br = 1'b1;
      tick(10);
      t  = cyc;
      br = 1'b0;
      push(0, 1'b1, t + 7);
      tick(10);
      t    = cyc;
      mode = 2'd1;
      push(0, 1'b0, t + 1);
      tick(3);
      t    = cyc;
      mode = 2'd2;
      push(0, 1'b1, t + 1);
      tick(3);
      t  = cyc;
      bl = 1'b0;
      push(0, 1'b0, t + 7);
      tick(10);
      t  = cyc;
      br = 1'b1;
      push(1, 1'b1, t + 7);
      tick(10);
      t  = cyc;
      br = 1'b0;
      push(1, 1'b0, t + 7);
      tick(10);
      drain("left right");

      // Reset while a request is pending; shoot held through release
      t  = cyc;
      bs = 1'b1;
      push(2, 1'b1, t + 6);
      tick(10);
      q   = cyc;
      rst = 1'b0;
      push(2, 1'b0, q);
      tick(3);
      q   = cyc;
      rst = 1'b1;
      push(2, 1'b1, q + 6);
      tick(8);
      bs = 1'b0;
      tick(10);
      f = cyc;
      frame(1'b1);
      push(2, 1'b0, f + 1);
      tick(1);
      frame(1'b0);
      tick(5);
      drain("reset pending");

      // Leaving play clears pending; presses outside play never fire
      t  = cyc;
      bs = 1'b1;
      push(2, 1'b1, t + 6);
      tick(8);
      bs = 1'b0;
      tick(4);
      t    = cyc;
      mode = 2'd1;
      push(2, 1'b0, t + 1);
      tick(10);
      bs = 1'b1;
      tick(10);
      bs = 1'b0;
      tick(10);
      frame(1'b1);
      tick(1);
      frame(1'b0);
      tick(3);
      bs = 1'b1;
      tick(10);
      mode = 2'd2;
      tick(5);
      bs = 1'b0;
      tick(10);
      frame(1'b1);
      tick(1);
      frame(1'b0);
      tick(3);
      drain("mode gating");

      // Press on frame_start: dropped when pending, accepted when idle
      t  = cyc;
      bs = 1'b1;
      push(2, 1'b1, t + 6);
      tick(8);
      bs = 1'b0;
      tick(10);
      b  = cyc;
      bs = 1'b1;
      tick(5);
      frame(1'b1);
      push(2, 1'b0, b + 6);
      tick(1);
      frame(1'b0);
      tick(2);
      bs = 1'b0;
      tick(10);
      frame(1'b1);
      tick(1);
      frame(1'b0);
      tick(3);
      c  = cyc;
      bs = 1'b1;
      tick(5);
      frame(1'b1);
      push(2, 1'b1, c + 6);
      tick(1);
      frame(1'b0);
      tick(2);
      bs = 1'b0;
      tick(10);
      f = cyc;
      frame(1'b1);
      push(2, 1'b0, f + 1);
      tick(1);
      frame(1'b0);
      tick(3);
      drain("frame collision");

      // Long hold with frame_start every 10 cycles
      base = shoot_rises;
      t    = cyc;
      bs   = 1'b1;
      push(2, 1'b1, t + 6);
      push(2, 1'b0, t + 10);
`ifdef BUTTON_AUTOFIRE_EN
      push(2, 1'b1, t + 46);
      push(2, 1'b0, t + 50);
      push(2, 1'b1, t + 86);
      push(2, 1'b0, t + 90);
      push(2, 1'b1, t + 126);
      push(2, 1'b0, t + 130);
`endif
      for (int i = 0; i < 130; i++) begin
         frame((i % 10) == 9);
         tick(1);
      end
      bs = 1'b0;
      frame(1'b0);
      tick(12);
`ifdef BUTTON_AUTOFIRE_EN
      chk("shoot requests over long hold", shoot_rises - base, 4);
`else
      chk("shoot requests over long hold", shoot_rises - base, 1);
`endif
      drain("long hold");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20'd500000, number of consecutive stable clk cycles required before an input change is accepted.
REQ-002 Parameter AUTOFIRE_CYCLES, default 26'd25000000, hold interval between repeated shoot requests (used only with BUTTON_AUTOFIRE_EN).
REQ-003 clk  input  1  system clock, single clock domain.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 btn_left_raw / btn_right_raw / btn_shoot_raw  input  1 each  asynchronous, bouncy pushbutton levels, active-high.
REQ-006 mode  input  2  game mode; 2 = play, all other values = not playing.
REQ-007 xCoord  input  11  current VGA pixel column.
REQ-008 yCoord  input  10  current VGA pixel row.
REQ-009 button_left / button_right  output  1 each  debounced level, valid only in play mode.
REQ-010 button_shoot  output  1  latched shoot request, held until consumed at frame start.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer; sync latency 2 cycles.
REQ-012 Each button SHALL have an independent 4-state FSM: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-013 IDLE->PRESS_WAIT on sync=1; PRESS_WAIT->HELD when sync stays 1 for DEBOUNCE_CYCLES cycles; PRESS_WAIT->IDLE if sync=0 before count completes, counter cleared.
REQ-014 HELD->RELEASE_WAIT on sync=0; RELEASE_WAIT->IDLE after DEBOUNCE_CYCLES consecutive 0s; RELEASE_WAIT->HELD if sync=1 before count completes.
REQ-015 Debounced level SHALL be 1 in HELD and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
REQ-016 Debounce counters SHALL be 20 bits, saturate at DEBOUNCE_CYCLES, never wrap.
REQ-017 button_left = debounced left AND mode==2 AND NOT debounced right; same for button_right; both pressed -> both 0.
REQ-018 frame_start SHALL be (xCoord==0 && yCoord==0), combinational.
REQ-019 Shoot press event = PRESS_WAIT->HELD transition of shoot FSM; it SHALL set shoot_pending when mode==2.
REQ-020 button_shoot = shoot_pending registered; stays 1 through the first frame_start cycle after setting, clears on the cycle after that frame_start.
REQ-021 Press event coinciding with frame_start while pending already 1: pending clears next cycle, new event dropped (one shot per frame max).
REQ-022 Press event coinciding with frame_start while pending 0: pending sets, consumed at the following frame_start.
REQ-023 mode leaving 2 SHALL clear shoot_pending next cycle; FSMs keep running so held buttons do not re-fire on mode entry.

Reset
REQ-024 rst low SHALL immediately force all FSMs to IDLE, all counters and synchronizer flops to 0, shoot_pending and autofire counter to 0.
REQ-025 All outputs SHALL be 0 during and on the first cycle after reset release.
REQ-026 Reset mid-debounce SHALL discard the partial count; a button held across reset release requires a full DEBOUNCE_CYCLES before acceptance.

Configuration
REQ-027 Macro BUTTON_AUTOFIRE_EN defined: while shoot FSM in HELD and mode==2, a 26-bit counter SHALL set shoot_pending every AUTOFIRE_CYCLES cycles after the initial press event; counter clears on leaving HELD.
REQ-028 BUTTON_AUTOFIRE_EN undefined: counter logic absent; exactly one shoot request per press regardless of hold time.

Verification (DEBOUNCE_CYCLES=4, AUTOFIRE_CYCLES=40 in bench)
REQ-029 btn_left_raw toggles 1/0 every 2 cycles for 20 cycles then held 1, mode=2 -> button_left rises exactly 2+4(+1 register) cycles after final hold begins, never earlier.
REQ-030 shoot held 10 cycles, mode=2, frame_start 30 cycles later -> button_shoot 1 from acceptance through frame_start cycle, 0 the next cycle.
REQ-031 Two shoot presses before one frame_start -> single button_shoot assertion consumed at that frame_start.
REQ-032 Left and right both held, mode=2 -> both outputs 0; release right -> button_left 1 after debounce.
REQ-033 Shoot pending, rst pulled low mid-frame -> button_shoot 0 same cycle; mode=1 with shoot held -> button_shoot never asserts.
REQ-034 BUTTON_AUTOFIRE_EN defined, shoot held 130 cycles with frame_start every 10 -> 4 requests (initial + 3 repeats); undefined -> 1 request.
